dpram_clr: RTL and testbench
============================

Name: dpram_clr

Overview:
- Parametrised true dual-port synchronous RAM with a built-in memory-clear sequencer.
- Successor to the fixed 64Kx8 system RAM: adds configurable width and depth, chip-select-gated reads, a selectable read-during-write mode and a defined write-collision policy.
- Fills the whole array with a pattern after reset or on request.
- Sits between the CPU/ULA bus arbiters and the block RAM in the Oric core.

Parameters:
- AW, 16, address width; depth = 2**AW words.
- DW, 8, data width.
- CLR_VAL, {DW{1'b1}}, fill pattern written by the clear sequencer.
- CLR_ON_RESET, 1, 1 = start a clear automatically after reset release.
- RDW_MODE, 0, same-port read-during-write: 0 = old data, 1 = new (written) data.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_d  in  DW  port A write data.
- a_ad  in  AW  port A address.
- a_cs  in  1  port A select.
- a_we  in  1  port A write enable; only valid with a_cs.
- a_q  out  DW  port A read data.
- b_d  in  DW  port B write data.
- b_ad  in  AW  port B address.
- b_cs  in  1  port B select.
- b_we  in  1  port B write enable.
- b_q  out  DW  port B read data.
- clr_req  in  1  single-cycle request to start a clear.
- clr_busy  out  1  high while the clear is in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset: while reset_n = 0, a_q = b_q = 0, clr_busy = 0, clr_done = 0, clear counter = 0, FSM = IDLE. Array contents are not reset.
- FSM states:
  - RST_WAIT: entered on reset release if CLR_ON_RESET = 1; moves to CLEAR on the first clock edge with reset_n = 1.
  - IDLE: normal access.
  - CLEAR: sequencer owns the array.
- FSM transitions:
  - IDLE -> CLEAR when clr_req = 1.
  - CLEAR -> IDLE after writing address 2**AW-1.
  - If CLR_ON_RESET = 0, reset releases straight to IDLE.
- CLEAR sweep: writes CLR_VAL to address cnt each cycle, cnt running 0..2**AW-1, exactly 2**AW cycles.
  - clr_busy = 1 for every cycle in CLEAR.
  - On the edge that writes the last address: FSM -> IDLE, clr_busy -> 0 and clr_done -> 1 for one cycle.
  - cnt returns to 0.
- During CLEAR:
  - Port writes are dropped.
  - a_q and b_q hold their last values.
  - clr_req is ignored; no queueing, no restart.
- Reads (IDLE): latency 1. x_q updates on the edge where x_cs = 1, to mem[x_ad]. With x_cs = 0, x_q holds.
- Writes (IDLE): mem[x_ad] <= x_d on the edge where x_cs & x_we.
- Same-port read-during-write:
  - RDW_MODE = 0: x_q gets the pre-write contents.
  - RDW_MODE = 1: x_q gets x_d.
- Cross-port read of the address the other port is writing in the same cycle: always returns the old data.
- Collision: both ports writing the same address in the same cycle means port A's data is stored and port B's write is discarded. Different addresses are written independently.
- Address wrap: AW-bit addresses, no bounds checking; the counter wraps only through the terminal transition.
- Reset mid-CLEAR: aborts immediately, all outputs return to their reset values and cnt = 0. After release the sweep restarts from address 0 if CLR_ON_RESET = 1, otherwise the memory is left partially cleared.
- clr_req in the same cycle as the terminal CLEAR write is ignored. clr_req on the first IDLE cycle after clr_done starts a new clear.
- The array maps to inferred dual-port block RAM; clear writes use port A's write path.

Test Plan:
- All tests use AW=4, DW=8, CLR_VAL=8'hFF, CLR_ON_RESET=1.
- Reset release -> clr_busy=1 for exactly 16 cycles, clr_done pulses once, all 16 words read back 8'hFF on both ports with 1-cycle latency.
- IDLE: A writes 8'h5A to 3, then B reads 3 -> b_q=8'h5A one cycle after the read edge. Then a_cs=0 for 4 cycles -> a_q holds.
- Same cycle, A writes 8'h11 and B writes 8'h22 to address 7 -> a subsequent read of 7 returns 8'h11. Same test with addresses 7 and 8 -> 8'h11 and 8'h22 respectively.
- RDW_MODE=0 vs 1: mem[2]=8'h33, A writes 8'h44 to 2 with a_cs=1 -> a_q=8'h33 (mode 0) or 8'h44 (mode 1). B reading 2 in the same cycle gets 8'h33 in both modes.
- clr_req in IDLE, then B writes 8'h77 to 5 while busy and clr_req is re-pulsed at cycle 6 -> write dropped, sweep still 16 cycles with one clr_done, mem[5]=8'hFF.
- reset_n pulsed low at clear cycle 9 -> outputs zero asynchronously; after release a full 16-cycle sweep from address 0 with one clr_done.

Source files
------------

// File: rtl/dpram_clr.sv
// True dual-port synchronous RAM with a built-in clear sequencer that fills
// the whole array with CLR_VAL after reset release or on request.
module dpram_clr #(
    parameter int unsigned       AW           = 16,
    parameter int unsigned       DW           = 8,
    parameter logic [DW-1:0]     CLR_VAL      = {DW{1'b1}},
    parameter bit                CLR_ON_RESET = 1'b1,
    parameter bit                RDW_MODE     = 1'b0
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [DW-1:0] a_d,
    input  logic [AW-1:0] a_ad,
    input  logic          a_cs,
    input  logic          a_we,
    output logic [DW-1:0] a_q,
    input  logic [DW-1:0] b_d,
    input  logic [AW-1:0] b_ad,
    input  logic          b_cs,
    input  logic          b_we,
    output logic [DW-1:0] b_q,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST_WAIT,
        ST_CLEAR
    } state_t;

    // Holding RST_WAIT during reset is equivalent to entering it on release.
    localparam state_t ST_RESET = CLR_ON_RESET ? ST_RST_WAIT : ST_IDLE;

    logic [DW-1:0] mem [DEPTH];

    state_t        state;
    logic [AW-1:0] cnt;

    logic          in_idle;
    logic          in_clear;
    logic          collide;
    logic          wa_en;
    logic [AW-1:0] wa_ad;
    logic [DW-1:0] wa_d;
    logic          wb_en;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RESET;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                ST_RST_WAIT: begin
                    state    <= ST_CLEAR;
                    clr_busy <= 1'b1;
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == '1) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_busy <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

    // Clear writes share port A's write path; port B loses same-address collisions.
    always_comb begin
        in_idle  = (state == ST_IDLE);
        in_clear = (state == ST_CLEAR);
        collide  = a_cs && a_we && b_cs && b_we && (a_ad == b_ad);
        wa_en    = in_clear || (in_idle && a_cs && a_we);
        wa_ad    = in_clear ? cnt : a_ad;
        wa_d     = in_clear ? CLR_VAL : a_d;
        wb_en    = in_idle && b_cs && b_we && !collide;
    end

    always_ff @(posedge clk_sys) begin
        if (wa_en) begin
            mem[wa_ad] <= wa_d;
        end
        if (wb_en) begin
            mem[b_ad] <= b_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (in_idle) begin
            if (a_cs) begin
                a_q <= (RDW_MODE && a_we) ? a_d : mem[a_ad];
            end
            if (b_cs) begin
                b_q <= (RDW_MODE && wb_en) ? b_d : mem[b_ad];
            end
        end
    end

endmodule

// File: tb/tb_dpram_clr.sv
// Directed bench for dpram_clr (AW=4, DW=8); a second instance with
// RDW_MODE=1 shares all inputs to compare read-during-write behaviour.
module tb_dpram_clr;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [7:0] a_d, b_d;
  logic [3:0] a_ad, b_ad;
  logic       a_cs, a_we, b_cs, b_we, clr_req;
  logic [7:0] a_q0, b_q0, a_q1, b_q1;
  logic       busy0, done0, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;
  int done_cnt;

  always #5 clk_sys = ~clk_sys;

  dpram_clr #(.AW(4), .DW(8), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1), .RDW_MODE(1'b0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_d(a_d), .a_ad(a_ad), .a_cs(a_cs), .a_we(a_we), .a_q(a_q0),
    .b_d(b_d), .b_ad(b_ad), .b_cs(b_cs), .b_we(b_we), .b_q(b_q0),
    .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
  );

  dpram_clr #(.AW(4), .DW(8), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1), .RDW_MODE(1'b1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_d(a_d), .a_ad(a_ad), .a_cs(a_cs), .a_we(a_we), .a_q(a_q1),
    .b_d(b_d), .b_ad(b_ad), .b_cs(b_cs), .b_we(b_we), .b_q(b_q1),
    .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_bus();
    a_cs = 1'b0; a_we = 1'b0; b_cs = 1'b0; b_we = 1'b0;
  endtask

  // Runs a bounded number of cycles and counts busy cycles and done pulses.
  task automatic count_sweep(input int start_busy);
    busy_cnt = start_busy;
    done_cnt = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0; clr_req = 1'b0;
    a_d = '0; b_d = '0; a_ad = '0; b_ad = '0;
    idle_bus();
    #2;
    chk("rst_a_q", a_q0, 8'h00);
    chk("rst_b_q", b_q0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;

    // Power-up sweep
    count_sweep(0);
    chk("pwr_busy_cycles", busy_cnt, 16);
    chk("pwr_done_pulses", done_cnt, 1);
    chk("pwr_busy_low", busy0, 1'b0);

    for (int unsigned i = 0; i < 16; i++) begin
      a_cs = 1'b1; a_ad = 4'(i);
      b_cs = 1'b1; b_ad = 4'(15 - i);
      tick();
      chk("fill_a", a_q0, 8'hFF);
      chk("fill_b", b_q0, 8'hFF);
    end
    idle_bus();

    // A writes, B reads back; then a_q holds with a_cs low
    a_cs = 1'b1; a_we = 1'b1; a_ad = 4'd3; a_d = 8'h5A;
    tick();
    idle_bus();
    b_cs = 1'b1; b_ad = 4'd3;
    tick();
    chk("b_read3", b_q0, 8'h5A);
    idle_bus();
    a_cs = 1'b1; a_ad = 4'd3;
    tick();
    chk("a_read3", a_q0, 8'h5A);
    a_cs = 1'b0; a_ad = 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("a_hold", a_q0, 8'h5A);
    end

    // Same-address collision: A wins
    a_cs = 1'b1; a_we = 1'b1; a_ad = 4'd7; a_d = 8'h11;
    b_cs = 1'b1; b_we = 1'b1; b_ad = 4'd7; b_d = 8'h22;
    tick();
    idle_bus();
    a_cs = 1'b1; a_ad = 4'd7;
    tick();
    chk("collide_7", a_q0, 8'h11);
    chk("collide_7_m1", a_q1, 8'h11);

    // Different addresses written independently
    a_cs = 1'b1; a_we = 1'b1; a_ad = 4'd7; a_d = 8'h00;
    tick();
    a_d = 8'h11;
    b_cs = 1'b1; b_we = 1'b1; b_ad = 4'd8; b_d = 8'h22;
    tick();
    idle_bus();
    a_cs = 1'b1; a_ad = 4'd7;
    b_cs = 1'b1; b_ad = 4'd8;
    tick();
    chk("indep_7", a_q0, 8'h11);
    chk("indep_8", b_q0, 8'h22);
    idle_bus();

    // Read-during-write: same port by mode, cross port always old
    a_cs = 1'b1; a_we = 1'b1; a_ad = 4'd2; a_d = 8'h33;
    tick();
    a_d = 8'h44;
    b_cs = 1'b1; b_ad = 4'd2;
    tick();
    chk("rdw_same_m0", a_q0, 8'h33);
    chk("rdw_same_m1", a_q1, 8'h44);
    chk("rdw_cross_m0", b_q0, 8'h33);
    chk("rdw_cross_m1", b_q1, 8'h33);
    idle_bus();
    a_cs = 1'b1; a_ad = 4'd2;
    tick();
    chk("rdw_after_m0", a_q0, 8'h44);
    chk("rdw_after_m1", a_q1, 8'h44);
    idle_bus();

    // Requested clear: port writes dropped, re-request ignored, outputs hold
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("req_busy", busy0, 1'b1);
    busy_cnt = 1;
    done_cnt = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (busy0) begin
        a_cs = 1'b1; a_ad = 4'd0;
        b_cs = 1'b1; b_we = 1'b1; b_ad = 4'd5; b_d = 8'h77;
        clr_req = (busy_cnt == 6);
      end
      tick();
      clr_req = 1'b0;
      if (busy0) begin
        busy_cnt++;
        chk("clr_a_hold", a_q0, 8'h44);
      end else begin
        idle_bus();
      end
      if (done0) done_cnt++;
    end
    chk("req_busy_cycles", busy_cnt, 16);
    chk("req_done_pulses", done_cnt, 1);
    b_cs = 1'b1; b_ad = 4'd5;
    a_cs = 1'b1; a_ad = 4'd2;
    tick();
    chk("drop_mem5", b_q0, 8'hFF);
    chk("clr_mem2", a_q0, 8'hFF);
    idle_bus();

    // Reset in the middle of a sweep
    a_cs = 1'b1; a_we = 1'b1; a_ad = 4'd15; a_d = 8'h12;
    tick();
    idle_bus();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 1;
    for (int unsigned i = 0; i < 20 && busy_cnt < 9; i++) begin
      tick();
      if (busy0) busy_cnt++;
    end
    chk("mid_reached_9", busy_cnt, 9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_done", done0, 1'b0);
    chk("mid_rst_a_q", a_q0, 8'h00);
    chk("mid_rst_b_q", b_q0, 8'h00);
    tick();
    reset_n = 1'b1;
    count_sweep(0);
    chk("rerun_busy_cycles", busy_cnt, 16);
    chk("rerun_done_pulses", done_cnt, 1);
    a_cs = 1'b1; a_ad = 4'd15;
    b_cs = 1'b1; b_ad = 4'd0;
    tick();
    chk("rerun_mem15", a_q0, 8'hFF);
    chk("rerun_mem0", b_q0, 8'hFF);
    idle_bus();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
